adc_ch_monitor: RTL and testbench



---
 rtl/adc_mon_pkg.sv | 39 +++
 rtl/adc_mon_lane.sv | 154 +++++++++++++++
 rtl/adc_ch_monitor.sv | 119 +++++++++++
 tb/tb_adc_ch_monitor.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_mon_pkg.sv
// -----------------------------------------------------------------------------
// adc_mon_pkg
// Shared constants, types and helpers for the multi-channel ADC monitor.
//   DW_DEF          default sample width
//   AVG_LOG2_MAX    upper bound of the averaging window exponent
//   DEB_CNT_MIN/MAX legal range of the debounce trip count
//   N_CH_MAX        largest supported channel count
//   DEB_W           width of the per-lane debounce counter
//   sample_t        signed sample type at the default width
//   ch_w()          channel index width, never narrower than one bit
//   lane_lo()       low bit offset of lane k inside a flattened bus
// -----------------------------------------------------------------------------
package adc_mon_pkg;

    localparam int DW_DEF       = 32;
    localparam int AVG_LOG2_MAX = 8;
    localparam int DEB_CNT_MIN  = 1;
    localparam int DEB_CNT_MAX  = 255;
    localparam int N_CH_MAX     = 32;
    localparam int DEB_W        = 8;

    typedef logic signed [DW_DEF-1:0] sample_t;

    // A single channel still needs a one-bit index port.
    function automatic int ch_w(input int n);
        int w;
        if (n <= 1) begin
            w = 1;
        end else begin
            w = $clog2(n);
        end
        return w;
    endfunction

    function automatic int lane_lo(input int k, input int dw);
        return k * dw;
    endfunction

endpackage

// File: rtl/adc_mon_lane.sv
// -----------------------------------------------------------------------------
// adc_mon_lane
// One ADC channel: sample capture, block averaging over 2^AVG_LOG2 samples,
// signed min/max window check with a saturating debounce counter.
//   i_clk, i_rst        clock, asynchronous active-low reset
//   i_tdata, i_tvalid   incoming sample and its valid strobe
//   i_max_thr/i_min_thr signed window limits (equality is in range)
//   i_intl_en           enables debounce counting and trips
//   i_intl_clr          clears the debounce counter unless a trip occurs
//   o_data              last captured sample
//   o_avg, o_avg_valid  last block average and its one-cycle update pulse
//   o_trip_set          combinational: this cycle's sample completes a trip
// -----------------------------------------------------------------------------
module adc_mon_lane
    import adc_mon_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int AVG_LOG2 = 4,
    parameter int DEB_CNT  = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [DW-1:0] i_tdata,
    input  logic          i_tvalid,
    input  logic [DW-1:0] i_max_thr,
    input  logic [DW-1:0] i_min_thr,
    input  logic          i_intl_en,
    input  logic          i_intl_clr,
    output logic [DW-1:0] o_data,
    output logic [DW-1:0] o_avg,
    output logic          o_avg_valid,
    output logic          o_trip_set
);

    localparam logic [DEB_W-1:0] DEB_LIM = DEB_W'(DEB_CNT);
    localparam logic [DEB_W-1:0] DEB_ONE = DEB_W'(1'b1);

    logic [DW-1:0]    data_r;
    logic [DW-1:0]    avg_r;
    logic             avg_valid_r;
    logic [DEB_W-1:0] deb_cnt_r;
    logic [DEB_W-1:0] deb_next_s;
    logic             oor_s;
    logic             trip_s;

    // Sample capture: hold the last valid sample.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            data_r <= {DW{1'b0}};
        end else if (i_tvalid) begin
            data_r <= i_tdata;
        end else begin
            data_r <= data_r;
        end
    end

    generate
        if (AVG_LOG2 == 0) begin : g_pass
            // Window of one sample: the average is the sample itself.
            always_ff @(posedge i_clk or negedge i_rst) begin
                if (!i_rst) begin
                    avg_r       <= {DW{1'b0}};
                    avg_valid_r <= 1'b0;
                end else begin
                    avg_valid_r <= i_tvalid;
                    if (i_tvalid) begin
                        avg_r <= i_tdata;
                    end else begin
                        avg_r <= avg_r;
                    end
                end
            end
        end else begin : g_avg
            localparam int AW = DW + AVG_LOG2;

            logic signed [AW-1:0]   acc_r;
            logic signed [AW-1:0]   sum_s;
            logic [AVG_LOG2-1:0]    cnt_r;

            // Running sum including the current sample; the guard bits
            // guarantee a full window of extreme samples cannot overflow.
            always_comb begin
                sum_s = acc_r + $signed({{AVG_LOG2{i_tdata[DW-1]}}, i_tdata});
            end

            // Accumulate; on the last sample of a window publish the
            // floor-divided mean and restart the window.
            always_ff @(posedge i_clk or negedge i_rst) begin
                if (!i_rst) begin
                    acc_r       <= {AW{1'b0}};
                    cnt_r       <= {AVG_LOG2{1'b0}};
                    avg_r       <= {DW{1'b0}};
                    avg_valid_r <= 1'b0;
                end else if (i_tvalid) begin
                    cnt_r <= cnt_r + AVG_LOG2'(1'b1);
                    if (&cnt_r) begin
                        avg_r       <= DW'(sum_s >>> AVG_LOG2);
                        avg_valid_r <= 1'b1;
                        acc_r       <= {AW{1'b0}};
                    end else begin
                        avg_r       <= avg_r;
                        avg_valid_r <= 1'b0;
                        acc_r       <= sum_s;
                    end
                end else begin
                    acc_r       <= acc_r;
                    cnt_r       <= cnt_r;
                    avg_r       <= avg_r;
                    avg_valid_r <= 1'b0;
                end
            end
        end
    endgenerate

    // Window check and next debounce count. A disabled lane holds at zero.
    always_comb begin
        oor_s      = ($signed(i_tdata) > $signed(i_max_thr)) ||
                     ($signed(i_tdata) < $signed(i_min_thr));
        deb_next_s = deb_cnt_r;
        if (!i_intl_en) begin
            deb_next_s = {DEB_W{1'b0}};
        end else if (i_tvalid) begin
            if (oor_s) begin
                if (deb_cnt_r >= DEB_LIM) begin
                    deb_next_s = DEB_LIM;
                end else begin
                    deb_next_s = deb_cnt_r + DEB_ONE;
                end
            end else begin
                deb_next_s = {DEB_W{1'b0}};
            end
        end else begin
            deb_next_s = deb_cnt_r;
        end
        trip_s = i_intl_en && i_tvalid && oor_s && (deb_next_s == DEB_LIM);
    end

    // Debounce counter; a trip in the same cycle as a clear is kept (fail-safe).
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            deb_cnt_r <= {DEB_W{1'b0}};
        end else if (i_intl_clr && !trip_s) begin
            deb_cnt_r <= {DEB_W{1'b0}};
        end else begin
            deb_cnt_r <= deb_next_s;
        end
    end

    assign o_data      = data_r;
    assign o_avg       = avg_r;
    assign o_avg_valid = avg_valid_r;
    assign o_trip_set  = trip_s;

endmodule

// File: rtl/adc_ch_monitor.sv
// -----------------------------------------------------------------------------
// adc_ch_monitor
// N_CH independent ADC lanes plus shared sticky-interlock bookkeeping.
//   i_clk, i_rst    clock, asynchronous active-low reset
//   s_axis_tdata    flattened samples, channel k at [k*DW +: DW]
//   s_axis_tvalid   per-channel valid, never back-pressured
//   i_max_thr       flattened signed upper limits
//   i_min_thr       flattened signed lower limits
//   i_intl_en       per-channel interlock enable
//   i_intl_clr      level clear of interlocks, debounce and first-trip record
//   o_data          last captured sample per channel
//   o_avg           last block average per channel
//   o_avg_valid     per-channel average update pulse
//   o_intl          sticky per-channel interlock
//   o_intl_any      OR of o_intl, registered alongside it
//   o_intl_first    lowest channel of the first trip since reset/clear
// -----------------------------------------------------------------------------
module adc_ch_monitor
    import adc_mon_pkg::*;
#(
    parameter int N_CH     = 10,
    parameter int DW       = DW_DEF,
    parameter int AVG_LOG2 = 4,
    parameter int DEB_CNT  = 3,
    parameter int CH_W     = ch_w(N_CH)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_CH*DW-1:0] s_axis_tdata,
    input  logic [N_CH-1:0]    s_axis_tvalid,
    input  logic [N_CH*DW-1:0] i_max_thr,
    input  logic [N_CH*DW-1:0] i_min_thr,
    input  logic [N_CH-1:0]    i_intl_en,
    input  logic               i_intl_clr,
    output logic [N_CH*DW-1:0] o_data,
    output logic [N_CH*DW-1:0] o_avg,
    output logic [N_CH-1:0]    o_avg_valid,
    output logic [N_CH-1:0]    o_intl,
    output logic               o_intl_any,
    output logic [CH_W-1:0]    o_intl_first
);

    logic [N_CH-1:0] trip_s;
    logic [N_CH-1:0] intl_next_s;
    logic [CH_W-1:0] first_idx_s;
    logic [N_CH-1:0] intl_r;
    logic            intl_any_r;
    logic            first_cap_r;
    logic [CH_W-1:0] first_r;

    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_lane
            adc_mon_lane #(
                .DW       (DW),
                .AVG_LOG2 (AVG_LOG2),
                .DEB_CNT  (DEB_CNT)
            ) u_lane (
                .i_clk       (i_clk),
                .i_rst       (i_rst),
                .i_tdata     (s_axis_tdata[lane_lo(k, DW) +: DW]),
                .i_tvalid    (s_axis_tvalid[k]),
                .i_max_thr   (i_max_thr[lane_lo(k, DW) +: DW]),
                .i_min_thr   (i_min_thr[lane_lo(k, DW) +: DW]),
                .i_intl_en   (i_intl_en[k]),
                .i_intl_clr  (i_intl_clr),
                .o_data      (o_data[lane_lo(k, DW) +: DW]),
                .o_avg       (o_avg[lane_lo(k, DW) +: DW]),
                .o_avg_valid (o_avg_valid[k]),
                .o_trip_set  (trip_s[k])
            );
        end
    endgenerate

    // Lowest-index priority encode of this cycle's trips, and next sticky
    // state: a clear drops old bits but never a trip arriving with it.
    always_comb begin
        first_idx_s = {CH_W{1'b0}};
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (trip_s[i]) begin
                first_idx_s = CH_W'(i);
            end else begin
                first_idx_s = first_idx_s;
            end
        end
        if (i_intl_clr) begin
            intl_next_s = trip_s;
        end else begin
            intl_next_s = intl_r | trip_s;
        end
    end

    // Sticky interlocks, their OR, and the first-trip record.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            intl_r      <= {N_CH{1'b0}};
            intl_any_r  <= 1'b0;
            first_cap_r <= 1'b0;
            first_r     <= {CH_W{1'b0}};
        end else begin
            intl_r     <= intl_next_s;
            intl_any_r <= |intl_next_s;
            if (i_intl_clr) begin
                first_cap_r <= |trip_s;
                first_r     <= first_idx_s;
            end else if (!first_cap_r && (|trip_s)) begin
                first_cap_r <= 1'b1;
                first_r     <= first_idx_s;
            end else begin
                first_cap_r <= first_cap_r;
                first_r     <= first_r;
            end
        end
    end

    assign o_intl       = intl_r;
    assign o_intl_any   = intl_any_r;
    assign o_intl_first = first_r;

endmodule

// File: tb/tb_adc_ch_monitor.sv
module tb_adc_ch_monitor;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int WIN = 4;   // 2^AVG_LOG2 with AVG_LOG2 = 2
    localparam int DEB = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] tdata, max_thr, min_thr;
    logic [N-1:0]   tvalid, en;
    logic           clr;
    logic [N*W-1:0] o_data, o_avg;
    logic [N-1:0]   o_avg_valid, o_intl;
    logic           o_intl_any;
    logic [1:0]     o_intl_first;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // behavioural model state
    logic [W-1:0] m_data [N];
    logic [W-1:0] m_avg  [N];
    bit           m_avgv [N];
    longint       m_sum  [N];
    int           m_n    [N];
    int           m_run  [N];
    bit [N-1:0]   m_intl;
    bit           m_cap;
    int           m_first;

    adc_ch_monitor #(.N_CH(N), .DW(W), .AVG_LOG2(2), .DEB_CNT(DEB)) dut (
        .i_clk(clk), .i_rst(rst),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
        .i_max_thr(max_thr), .i_min_thr(min_thr),
        .i_intl_en(en), .i_intl_clr(clr),
        .o_data(o_data), .o_avg(o_avg), .o_avg_valid(o_avg_valid),
        .o_intl(o_intl), .o_intl_any(o_intl_any), .o_intl_first(o_intl_first)
    );

    always #5 clk = ~clk;

    function automatic longint floor_div(input longint v, input longint d);
        longint q;
        q = v / d;
        if (v < 0 && (v % d) != 0) q = q - 1;
        return q;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_data[k] = '0; m_avg[k] = '0; m_avgv[k] = 1'b0;
            m_sum[k] = 0; m_n[k] = 0; m_run[k] = 0;
        end
        m_intl = '0; m_cap = 1'b0; m_first = 0;
    endtask

    task automatic model_step();
        bit [N-1:0] trip;
        int s, mx, mn, low;
        trip = '0;
        for (int k = 0; k < N; k++) begin
            s  = tdata[k*W +: W];
            mx = max_thr[k*W +: W];
            mn = min_thr[k*W +: W];
            m_avgv[k] = 1'b0;
            if (tvalid[k]) begin
                m_data[k] = tdata[k*W +: W];
                m_sum[k] += longint'(s);
                m_n[k]++;
                if (m_n[k] == WIN) begin
                    m_avg[k]  = W'(floor_div(m_sum[k], WIN));
                    m_avgv[k] = 1'b1;
                    m_sum[k]  = 0;
                    m_n[k]    = 0;
                end
            end
            if (!en[k]) m_run[k] = 0;
            else if (tvalid[k]) begin
                if (s > mx || s < mn) begin
                    m_run[k] = (m_run[k] + 1 > DEB) ? DEB : m_run[k] + 1;
                    if (m_run[k] == DEB) trip[k] = 1'b1;
                end else m_run[k] = 0;
            end
        end
        low = 0;
        for (int k = N - 1; k >= 0; k--) if (trip[k]) low = k;
        if (clr) begin
            m_intl = trip;
            for (int k = 0; k < N; k++) if (!trip[k]) m_run[k] = 0;
            m_cap   = (trip != 0);
            m_first = (trip != 0) ? low : 0;
        end else begin
            m_intl |= trip;
            if (!m_cap && trip != 0) begin
                m_cap = 1'b1; m_first = low;
            end
        end
    endtask

    // Per-cycle comparison of every output against the model.
    logic [N*W-1:0] e_data, e_avg;
    logic [N-1:0]   e_avgv;
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < N; k++) begin
                e_data[k*W +: W] = m_data[k];
                e_avg[k*W +: W]  = m_avg[k];
                e_avgv[k]        = m_avgv[k];
            end
            n_tests++;
            if (o_data !== e_data || o_avg !== e_avg || o_avg_valid !== e_avgv ||
                o_intl !== m_intl || o_intl_any !== (m_intl != 0) ||
                o_intl_first !== 2'(m_first)) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t data %h want %h avg %h want %h avgv %b want %b intl %b want %b any %b first %0d want %0d",
                         $time, o_data, e_data, o_avg, e_avg, o_avg_valid, e_avgv,
                         o_intl, m_intl, o_intl_any, o_intl_first, m_first);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst) model_step();
        @(negedge clk);
    endtask

    task automatic send(input int k, input logic [W-1:0] v);
        tvalid = '0;
        tdata[k*W +: W] = v;
        tvalid[k] = 1'b1;
        cyc();
        tvalid = '0;
    endtask

    int seq_a[4] = '{-3, 5, 7, 1};
    int seq_b[4] = '{-1, -1, -1, -2};
    int seq_d[6] = '{101, 150, 50, 101, 101, 101};
    int pulses;
    int guard;

    initial begin
        rst = 1'b0; tdata = '0; tvalid = '0; en = '0; clr = 1'b0;
        for (int k = 0; k < N; k++) begin
            max_thr[k*W +: W] = 32'sd100;
            min_thr[k*W +: W] = -32'sd100;
        end
        model_reset();
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data", o_data[63:0], 64'h0);
        chk("rst_intl", {o_intl, o_intl_any, o_intl_first, o_avg_valid}, 64'h0);
        #2 rst = 1'b1;

        // capture
        send(2, 32'h0000_1234);
        chk("cap_ch2", o_data[2*W +: W], 64'h1234);
        chk("cap_ch0", o_data[0 +: W], 64'h0);
        chk("cap_ch3", o_data[3*W +: W], 64'h0);

        // averaging
        for (int i = 0; i < 4; i++) begin
            send(0, W'(seq_a[i]));
            if (i == 2) chk("avg_no_early_pulse", o_avg_valid[0], 64'h0);
        end
        chk("avg_first", o_avg[0 +: W], 64'h2);
        chk("avg_pulse", o_avg_valid[0], 64'h1);
        cyc();
        chk("avg_single_pulse", o_avg_valid[0], 64'h0);
        for (int i = 0; i < 4; i++) send(0, W'(seq_b[i]));
        chk("avg_neg", o_avg[0 +: W], 64'hFFFF_FFFE);

        // debounce on ch1
        en = 4'hF;
        for (int i = 0; i < 6; i++) begin
            send(1, W'(seq_d[i]));
            if (i == 4) chk("deb_not_yet", o_intl, 64'h0);
        end
        chk("deb_trip", o_intl, 64'h2);
        chk("deb_any", o_intl_any, 64'h1);
        chk("deb_first", o_intl_first, 64'h1);

        // clear, then simultaneous trip of ch3 and ch1, later ch0
        clr = 1'b1; cyc(); clr = 1'b0;
        chk("clr_intl", {o_intl, o_intl_any, o_intl_first}, 64'h0);
        tdata[1*W +: W] = 32'sd200; tdata[3*W +: W] = 32'sd200;
        tvalid = 4'b1010;
        repeat (3) cyc();
        tvalid = '0;
        chk("prio_first", o_intl_first, 64'h1);
        chk("prio_intl", o_intl, 64'hA);
        repeat (3) send(0, 32'sd200);
        chk("sticky_intl", o_intl, 64'hB);
        chk("sticky_first", o_intl_first, 64'h1);

        // clear coinciding with ch2's trip
        send(2, -32'sd200);
        send(2, -32'sd200);
        clr = 1'b1;
        send(2, -32'sd200);
        clr = 1'b0;
        chk("clrtrip_intl", o_intl, 64'h4);
        chk("clrtrip_first", o_intl_first, 64'h2);

        // disabled channel never trips
        clr = 1'b1; cyc(); clr = 1'b0;
        en = 4'b0111;
        repeat (10) send(3, 32'sd500);
        chk("dis_no_trip", o_intl, 64'h0);

        // reset mid-window
        en = '0;
        guard = 0;
        while (m_n[0] != 0 && guard < 8) begin send(0, 32'sd8); guard++; end
        send(0, 32'sd50);
        send(0, 32'sd50);
        #2 rst = 1'b0;
        model_reset();
        cyc();
        chk("rst_mid_avg", o_avg[0 +: W], 64'h0);
        #2 rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            send(0, 32'sd8);
            pulses += int'(o_avg_valid[0]);
        end
        chk("rst_avg_val", o_avg[0 +: W], 64'h8);
        cyc();
        pulses += int'(o_avg_valid[0]);
        chk("rst_avg_pulses", pulses, 64'h1);

        // randomized traffic
        en = 4'hF;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 3) == 0) tdata[k*W +: W] = $urandom;
                else tdata[k*W +: W] = W'($signed($urandom_range(0, 300)) - 150);
                if ($urandom_range(0, 99) == 0) begin
                    max_thr[k*W +: W] = W'($signed($urandom_range(0, 200)) - 50);
                    min_thr[k*W +: W] = W'($signed($urandom_range(0, 200)) - 150);
                end
            end
            tvalid = 4'($urandom);
            if ($urandom_range(0, 49) == 0) en = 4'($urandom);
            clr = ($urandom_range(0, 39) == 0);
            cyc();
        end
        tvalid = '0; clr = 1'b0;
        cyc();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
